// File: rtl/alu_muldiv.sv
// alu_muldiv: 32-bit multiply/divide unit with HI/LO registers.
// Multiply is a radix-2 shift-add over 32 cycles. Divide is a restoring
// shift-subtract over 32 cycles. Both work on operand magnitudes, and a
// two-cycle FIX state applies the sign correction before HI/LO are written.
// The negation is registered in the first FIX cycle so that the 64-bit
// negate is not in series with the HI/LO write path.
module alu_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // Two's-complement magnitude of a signed 32-bit value (0x80000000 maps to itself).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    // Conditional 32-bit negation.
    function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] v);
        cneg32 = neg ? (~v + 32'd1) : v;
    endfunction

    // Conditional 64-bit negation.
    function automatic logic [63:0] cneg64(input logic neg, input logic [63:0] v);
        cneg64 = neg ? (~v + 64'd1) : v;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        fix_ph_q, fix_ph_d;     // 0: compute corrected result, 1: write HI/LO
    logic [63:0] acc_q, acc_d;           // MUL: product; DIV: {remainder, quotient}
    logic [63:0] opa_q, opa_d;           // MUL: shifting multiplicand
    logic [31:0] opb_q, opb_d;           // MUL: shifting multiplier; DIV: divisor
    logic        neg_lo_q, neg_lo_d;     // negate product / quotient
    logic        neg_hi_q, neg_hi_d;     // negate remainder (dividend sign)
    logic        is_div_q, is_div_d;
    logic        dz_q, dz_d;             // divisor was zero
    logic [63:0] res_q, res_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        busy_q;

    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;

    assign div_shift_s = {acc_q[63:32], acc_q[31]};
    assign div_diff_s  = div_shift_s - {1'b0, opb_q};

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Next-state and datapath control for the IDLE/MUL/DIV/FIX sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_ph_d = fix_ph_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        res_d    = res_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    // A flush discards any start presented in the same cycle.
                    state_d = S_IDLE;
                end else if (start_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            if (op_i == OP_MULT) begin
                                opa_d    = {32'd0, abs32(a_i)};
                                opb_d    = abs32(b_i);
                                neg_lo_d = a_i[31] ^ b_i[31];
                            end else begin
                                opa_d    = {32'd0, a_i};
                                opb_d    = b_i;
                                neg_lo_d = 1'b0;
                            end
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                            acc_d    = 64'd0;
                            cnt_d    = 5'd0;
                            fix_ph_d = 1'b0;
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (op_i == OP_DIV) begin
                                acc_d    = {32'd0, abs32(a_i)};
                                opb_d    = abs32(b_i);
                                neg_lo_d = a_i[31] ^ b_i[31];
                                neg_hi_d = a_i[31];
                            end else begin
                                acc_d    = {32'd0, a_i};
                                opb_d    = b_i;
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                            end
                            is_div_d = 1'b1;
                            dz_d     = (b_i == 32'd0);
                            cnt_d    = 5'd0;
                            fix_ph_d = 1'b0;
                            state_d  = S_DIV;
                        end
                        OP_MTHI: begin
                            hi_d = a_i;
                        end
                        OP_MTLO: begin
                            lo_d = a_i;
                        end
                        default: begin
                            // Reserved op codes are ignored.
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    opa_d = {opa_q[62:0], 1'b0};
                    opb_d = {1'b0, opb_q[31:1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        fix_ph_d = 1'b0;
                        state_d  = S_FIX;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end

            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!div_diff_s[32]) begin
                        acc_d = {div_diff_s[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {div_shift_s[31:0], acc_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        fix_ph_d = 1'b0;
                        state_d  = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end

            S_FIX: begin
                if (flush_i) begin
                    fix_ph_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (!fix_ph_q) begin
                    if (is_div_q) begin
                        res_d[63:32] = cneg32(neg_hi_q, acc_q[63:32]);
                        if (dz_q) begin
                            res_d[31:0] = 32'hFFFF_FFFF;
                        end else begin
                            res_d[31:0] = cneg32(neg_lo_q, acc_q[31:0]);
                        end
                    end else begin
                        res_d = cneg64(neg_lo_q, acc_q);
                    end
                    fix_ph_d = 1'b1;
                end else begin
                    hi_d     = res_q[63:32];
                    lo_d     = res_q[31:0];
                    done_d   = 1'b1;
                    fix_ph_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            fix_ph_q <= 1'b0;
            acc_q    <= 64'd0;
            opa_q    <= 64'd0;
            opb_q    <= 32'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            res_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_ph_q <= fix_ph_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    // Architectural HI/LO as the bench expects them to be.
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    alu_muldiv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] rop, input logic [31:0] ra,
                                               input logic [31:0] rb);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     qv, rv;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        ua = {32'd0, ra};
        ub = {32'd0, rb};
        case (rop)
            3'd0: ref_result = sa * sb;
            3'd1: ref_result = ua * ub;
            3'd2: begin
                if (rb == 32'd0) begin
                    ref_result = {ra, 32'hFFFF_FFFF};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    qv = sq;
                    rv = sr;
                    ref_result = {rv[31:0], qv[31:0]};
                end
            end
            3'd3: begin
                if (rb == 32'd0) begin
                    ref_result = {ra, 32'hFFFF_FFFF};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    qv = uq;
                    rv = ur;
                    ref_result = {rv[31:0], qv[31:0]};
                end
            end
            default: ref_result = {hi_m, lo_m};
        endcase
    endfunction

    // Multi-cycle op: checks busy/done every cycle, injects an ignored start,
    // and checks the result once the operation completes.
    task automatic run_long(input logic [2:0] lop, input logic [31:0] la, input logic [31:0] lb);
        logic [63:0] exp_v;
        exp_v = ref_result(lop, la, lb);
        @(negedge clk);
        start = 1'b1; op = lop; a = la; b = lb;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        for (int c = 0; c <= 33; c++) begin
            check_eq("busy_during_op", 64'(busy), 64'd1);
            check_eq("done_during_op", 64'(done), 64'd0);
            if (c == 0 || c == 33) begin
                check_eq("hilo_hold_during_op", {hi, lo}, {hi_m, lo_m});
            end
            if (c == 5) begin
                @(negedge clk);
                start = 1'b1; op = 3'd4; a = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq("busy_after_op", 64'(busy), 64'd0);
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("result", {hi, lo}, exp_v);
        hi_m = exp_v[63:32];
        lo_m = exp_v[31:0];
    endtask

    // Single-cycle request (MTHI/MTLO/reserved), optionally with flush.
    task automatic run_short(input logic [2:0] sop, input logic [31:0] sa, input logic sflush);
        @(negedge clk);
        start = 1'b1; op = sop; a = sa; b = $urandom; flush = sflush;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        if (!sflush) begin
            if (sop == 3'd4) hi_m = sa;
            else if (sop == 3'd5) lo_m = sa;
        end
        check_eq("short_hilo", {hi, lo}, {hi_m, lo_m});
        check_eq("short_busy", 64'(busy), 64'd0);
        check_eq("short_done", 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] hold_v;
        logic        done_seen;
        int          sel;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        // Directed results.
        run_long(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        check_eq("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_long(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_long(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        check_eq("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_long(3'd3, 32'h0000_0007, 32'h0000_0000);
        check_eq("divu_by_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_long(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        run_long(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
        check_eq("div_neg_by_zero", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // MTHI/MTLO, reserved ops, flush beating start in IDLE.
        run_short(3'd4, 32'hCAFE_F00D, 1'b0);
        run_short(3'd5, 32'h1357_9BDF, 1'b0);
        run_short(3'd6, 32'hDEAD_BEEF, 1'b0);
        run_short(3'd7, 32'hDEAD_BEEF, 1'b0);
        run_short(3'd5, 32'hAAAA_5555, 1'b1);
        run_short(3'd0, 32'h0000_0005, 1'b1);

        // Flush mid-multiply: back to idle, HI/LO kept, no done.
        hold_v = {hi_m, lo_m};
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("flush_no_done", 64'(done_seen), 64'd0);
        check_eq("flush_hilo", {hi, lo}, hold_v);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 3);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 1) begin
                ra = $urandom_range(0, 100);
                rb = $urandom_range(1, 9);
                if ($urandom_range(0, 1) == 1) ra = -ra;
            end else if (sel == 2) begin
                rb = 32'd0;
            end else if (sel == 3) begin
                ra = 32'h8000_0000;
                rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
            end
            rop = 3'($urandom_range(0, 7));
            if (rop <= 3'd3) run_long(rop, ra, rb);
            else run_short(rop, ra, 1'b0);
        end

        // Reset during a divide, then an MTLO on the first edge after release.
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_busy", 64'(busy), 64'd0);
        check_eq("async_reset_done", 64'(done), 64'd0);
        check_eq("async_reset_hilo", {hi, lo}, 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; op = 3'd5; a = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("mtlo_after_reset", {hi, lo}, 64'h0000_0000_1234_5678);
        check_eq("mtlo_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_eq("mtlo_no_done", 64'(done), 64'd0);
        check_eq("final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
